// File: rtl/proc_isa_pkg.sv
// Shared instruction-set constants for pipelined_processor and its instruction source.
// Latency: none (declarations only).
// Backpressure: n/a; field helpers are pure functions.
package proc_isa_pkg;

   localparam logic [5:0]  OP_ADD   = 6'd0;
   localparam logic [5:0]  OP_SUB   = 6'd1;
   localparam logic [5:0]  OP_LOAD  = 6'd2;
   localparam logic [5:0]  OP_NOP   = 6'h3F;
   localparam logic [31:0] NOP_WORD = 32'hFC00_0000;

   localparam int OPC_HI = 31;
   localparam int OPC_LO = 26;
   localparam int RD_HI  = 25;
   localparam int RD_LO  = 21;
   localparam int RS_HI  = 20;
   localparam int RS_LO  = 16;
   localparam int RT_HI  = 15;
   localparam int RT_LO  = 11;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

   function automatic logic [5:0] f_opc(input logic [31:0] w);
      return w[OPC_HI:OPC_LO];
   endfunction

   function automatic logic [4:0] f_rd(input logic [31:0] w);
      return w[RD_HI:RD_LO];
   endfunction

   function automatic logic [4:0] f_rs(input logic [31:0] w);
      return w[RS_HI:RS_LO];
   endfunction

   function automatic logic [4:0] f_rt(input logic [31:0] w);
      return w[RT_HI:RT_LO];
   endfunction

endpackage

// File: rtl/hazard_check.sv
// RAW hazard detector: candidate sources vs rd of real instructions in the last HAZARD_WINDOW slots.
// Latency: hazard is combinational; the history shifts one slot per cycle when shift is high.
// Backpressure: none; the owner decides whether a slot was real (issued) or a bubble/stall.
module hazard_check
   import proc_isa_pkg::*;
#(
   parameter int HAZARD_WINDOW = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       clear,
   input  logic       shift,
   input  logic       slot_real,
   input  logic [4:0] slot_rd,
   input  logic [5:0] cand_opc,
   input  logic [4:0] cand_rs,
   input  logic [4:0] cand_rt,
   output logic       hazard
);

   logic [HAZARD_WINDOW-1:0] hist_vld;
   logic [4:0]               hist_rd [HAZARD_WINDOW];
   logic                     use_rs;
   logic                     use_rt;

   // Slot history: entry 0 is the most recent slot; bubbles and stalls shift in as invalid.
   always_ff @(posedge clk) begin
      if (reset || clear) begin
         hist_vld <= '0;
         for (int i = 0; i < HAZARD_WINDOW; i++) hist_rd[i] <= 5'd0;
      end else if (shift) begin
         for (int i = HAZARD_WINDOW-1; i > 0; i--) begin
            hist_vld[i] <= hist_vld[i-1];
            hist_rd[i]  <= hist_rd[i-1];
         end
         hist_vld[0] <= slot_real;
         hist_rd[0]  <= slot_rd;
      end
   end

   // Compare the candidate's live sources against every valid non-R0 producer in the window.
   always_comb begin
      use_rs = (cand_opc == OP_ADD) || (cand_opc == OP_SUB) || (cand_opc == OP_LOAD);
      use_rt = (cand_opc == OP_ADD) || (cand_opc == OP_SUB);
      hazard = 1'b0;
      for (int i = 0; i < HAZARD_WINDOW; i++) begin
         if (hist_vld[i] && (hist_rd[i] != 5'd0) &&
             ((use_rs && (hist_rd[i] == cand_rs)) || (use_rt && (hist_rd[i] == cand_rt))))
            hazard = 1'b1;
      end
   end

endmodule

// File: rtl/instr_issue_unit.sv
// Program-memory instruction source: issues prog_len words, then DRAIN_CYCLES NOPs, then pulses done.
// Latency: start at edge N puts mem[0] on instruction_out after edge N+1; all outputs registered.
// Backpressure: stall holds pc and issues a NOP; HAZARD_BUBBLE_EN adds RAW hazard bubbles.
module instr_issue_unit
   import proc_isa_pkg::*;
#(
   parameter int DEPTH        = 16,
   parameter int AW           = 4,
   parameter int DRAIN_CYCLES = 4
`ifdef HAZARD_BUBBLE_EN
   ,
   parameter int HAZARD_WINDOW = 2
`endif
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          load_en,
   input  logic [AW-1:0] load_addr,
   input  logic [31:0]   load_data,
   input  logic [AW:0]   prog_len,
   input  logic          start,
   input  logic          stall,
   output logic [31:0]   instruction_out,
   output logic          issue_valid,
   output logic          busy,
   output logic          done,
   output logic [15:0]   bubble_count
);

   localparam int          DW      = $clog2(DRAIN_CYCLES + 1);
   localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);
   localparam logic [DW-1:0] DC_L  = DW'(DRAIN_CYCLES);

   state_t        state;
   logic [AW-1:0] pc;
   logic [AW:0]   len_q;
   logic [DW-1:0] dcnt;
   logic [31:0]   mem [DEPTH];
   logic [31:0]   fetch_word;
   logic [AW:0]   len_in;
   logic          last_idx;
   logic          hazard;

   assign fetch_word = mem[pc];
   assign len_in     = (prog_len > DEPTH_L) ? DEPTH_L : prog_len;
   assign last_idx   = (({1'b0, pc} + {{AW{1'b0}}, 1'b1}) == len_q);
   assign busy       = (state != ST_IDLE);

   // Program memory: writable only while idle, never reset.
   always_ff @(posedge clk) begin
      if (load_en && (state == ST_IDLE)) mem[load_addr] <= load_data;
   end

   // Issue FSM with registered instruction/valid/done outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state           <= ST_IDLE;
         pc              <= '0;
         len_q           <= '0;
         dcnt            <= '0;
         instruction_out <= NOP_WORD;
         issue_valid     <= 1'b0;
         done            <= 1'b0;
      end else begin
         instruction_out <= NOP_WORD;
         issue_valid     <= 1'b0;
         done            <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start) begin
                  if (len_in != '0) begin
                     state <= ST_ISSUE;
                     pc    <= '0;
                     len_q <= len_in;
                  end else begin
                     done <= 1'b1;
                  end
               end
            end
            ST_ISSUE: begin
               if (!stall && !hazard) begin
                  instruction_out <= fetch_word;
                  issue_valid     <= 1'b1;
                  if (last_idx) begin
                     state <= ST_DRAIN;
                     dcnt  <= '0;
                  end else begin
                     pc <= pc + 1'b1;
                  end
               end
            end
            ST_DRAIN: begin
               // The state lingers one extra cycle so busy stays high through the done cycle.
               if (dcnt == DC_L) begin
                  state <= ST_IDLE;
                  dcnt  <= '0;
                  pc    <= '0;
               end else begin
                  dcnt <= dcnt + 1'b1;
                  done <= (dcnt == DC_L - 1'b1);
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

`ifdef HAZARD_BUBBLE_EN
   logic [15:0] bub_q;
   logic        slot_real;

   assign slot_real    = !stall && !hazard;
   assign bubble_count = bub_q;

   hazard_check #(
      .HAZARD_WINDOW(HAZARD_WINDOW)
   ) u_hazard (
      .clk       (clk),
      .reset     (reset),
      .clear     (state == ST_IDLE),
      .shift     (state == ST_ISSUE),
      .slot_real (slot_real),
      .slot_rd   (f_rd(fetch_word)),
      .cand_opc  (f_opc(fetch_word)),
      .cand_rs   (f_rs(fetch_word)),
      .cand_rt   (f_rt(fetch_word)),
      .hazard    (hazard)
   );

   // Bubble counter: cleared on a real start, counts only unstalled hazard slots, saturates.
   always_ff @(posedge clk) begin
      if (reset) begin
         bub_q <= '0;
      end else if ((state == ST_IDLE) && start && (len_in != '0)) begin
         bub_q <= '0;
      end else if ((state == ST_ISSUE) && !stall && hazard && (bub_q != 16'hFFFF)) begin
         bub_q <= bub_q + 16'd1;
      end
   end
`else
   assign hazard       = 1'b0;
   assign bubble_count = 16'd0;
`endif

endmodule

// File: tb/tb_instr_issue_unit.sv
// Self-checking bench for instr_issue_unit: directed scenarios plus randomized programs and stalls.
// Expected output streams come from a slot-by-slot reference built from the issue rules.
// Inputs change 1ns after the rising edge; outputs are sampled at the same point.
module tb_instr_issue_unit;

   localparam logic [31:0] NOP = 32'hFC00_0000;
`ifdef HAZARD_BUBBLE_EN
   localparam bit HZ = 1'b1;
`else
   localparam bit HZ = 1'b0;
`endif
   localparam int WIN = 2;

   logic        clk = 1'b0;
   logic        reset;
   logic        load_en;
   logic [3:0]  load_addr;
   logic [31:0] load_data;
   logic [4:0]  prog_len;
   logic        start;
   logic        stall;
   logic [31:0] instruction_out;
   logic        issue_valid;
   logic        busy;
   logic        done;
   logic [15:0] bubble_count;

   int n_chk = 0;
   int n_err = 0;
   logic [31:0] ref_mem [16];
   logic [31:0] prog1 [4];

   instr_issue_unit dut (
      .clk             (clk),
      .reset           (reset),
      .load_en         (load_en),
      .load_addr       (load_addr),
      .load_data       (load_data),
      .prog_len        (prog_len),
      .start           (start),
      .stall           (stall),
      .instruction_out (instruction_out),
      .issue_valid     (issue_valid),
      .busy            (busy),
      .done            (done),
      .bubble_count    (bubble_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load_word(input int addr, input logic [31:0] data);
      load_en   = 1'b1;
      load_addr = addr[3:0];
      load_data = data;
      ref_mem[addr] = data;
      tick();
      load_en = 1'b0;
   endtask

   // Producer rds of the most recent slots (index 0 newest, -1 = no real instruction).
   function automatic bit raw_hazard(input logic [31:0] w, input int recent[$]);
      int op = int'(w[31:26]);
      int rs = int'(w[20:16]);
      int rt = int'(w[15:11]);
      bit urs = (op == 0) || (op == 1) || (op == 2);
      bit urt = (op == 0) || (op == 1);
      foreach (recent[i])
         if (recent[i] > 0 && ((urs && recent[i] == rs) || (urt && recent[i] == rt))) return 1'b1;
      return 1'b0;
   endfunction

   task automatic run_prog(input int len_req, input int stall_pct, input logic [31:0] force_mask,
                           input bit wr_at_start, input bit junk, input string tag,
                           output int done_at);
      int len = (len_req > 16) ? 16 : len_req;
      logic [31:0] e_ins[$];
      bit e_vld[$];
      bit e_done[$];
      bit e_busy[$];
      bit stl[$];
      int recent[$];
      int bubbles = 0;
      int idx = 0;
      logic [31:0] w0;
      done_at = -1;
      if (wr_at_start) begin
         w0 = $urandom;
         load_en = 1'b1;
         load_addr = 4'd0;
         load_data = w0;
         ref_mem[0] = w0;
      end
      // Reference stream: one entry per cycle after the start edge.
      while (idx < len) begin
         int k = stl.size();
         bit s = (k < 32 && force_mask[k]) || (int'($urandom_range(99)) < stall_pct);
         stl.push_back(s);
         if (s || (HZ && raw_hazard(ref_mem[idx], recent))) begin
            if (!s) bubbles++;
            e_ins.push_back(NOP); e_vld.push_back(0); e_done.push_back(0); e_busy.push_back(1);
            recent.push_front(-1);
         end else begin
            e_ins.push_back(ref_mem[idx]); e_vld.push_back(1); e_done.push_back(0); e_busy.push_back(1);
            recent.push_front(int'(ref_mem[idx][25:21]));
            idx++;
         end
         while (recent.size() > WIN) void'(recent.pop_back());
      end
      for (int d = 1; d <= 4; d++) begin
         stl.push_back(($urandom_range(99) < 30));
         e_ins.push_back(NOP); e_vld.push_back(0); e_done.push_back(d == 4); e_busy.push_back(1);
      end
      stl.push_back(1'b0);
      e_ins.push_back(NOP); e_vld.push_back(0); e_done.push_back(0); e_busy.push_back(0);

      prog_len = len_req[4:0];
      start = 1'b1;
      tick();
      start = 1'b0;
      load_en = 1'b0;
      chk({tag, "_start_busy"}, 32'(busy), 32'd1);
      chk({tag, "_start_ins"}, instruction_out, NOP);
      for (int k = 0; k < e_ins.size(); k++) begin
         stall = stl[k];
         if (junk) begin
            load_en = 1'b1;
            load_addr = (k % 2 == 0) ? 4'd0 : 4'($urandom);
            load_data = (k == 0) ? 32'hDEAD_BEEF : $urandom;
         end
         tick();
         chk($sformatf("%s_ins%0d", tag, k), instruction_out, e_ins[k]);
         chk($sformatf("%s_vld%0d", tag, k), 32'(issue_valid), 32'(e_vld[k]));
         chk($sformatf("%s_done%0d", tag, k), 32'(done), 32'(e_done[k]));
         chk($sformatf("%s_busy%0d", tag, k), 32'(busy), 32'(e_busy[k]));
         if (done && done_at < 0) done_at = k;
      end
      stall = 1'b0;
      load_en = 1'b0;
      chk({tag, "_bubbles"}, 32'(bubble_count), 32'(bubbles));
   endtask

   initial begin
      int dat;
      int rl;
      prog1[0] = 32'h0022_1800;
      prog1[1] = 32'h0481_2800;
      prog1[2] = 32'h08C7_0064;
      prog1[3] = 32'h0106_2000;
      reset = 1'b1; load_en = 1'b0; load_addr = '0; load_data = '0;
      prog_len = '0; start = 1'b0; stall = 1'b0;
      tick(); tick();
      chk("rst_ins", instruction_out, NOP);
      chk("rst_vld", 32'(issue_valid), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_bub", 32'(bubble_count), 32'd0);
      reset = 1'b0;
      tick();

      // Scenario 1 / 6: plain run of the reference program.
      for (int i = 0; i < 4; i++) load_word(i, prog1[i]);
      run_prog(4, 0, 32'd0, 1'b0, 1'b0, "t1", dat);
      chk("t1_done_slot", 32'(dat), HZ ? 32'd11 : 32'd7);
      chk("t6_bubble_total", 32'(bubble_count), HZ ? 32'd4 : 32'd0);

      // Scenario 2: two stall cycles right after the first word.
      run_prog(4, 0, 32'h6, 1'b0, 1'b0, "t2", dat);

      // Scenario 3: empty program.
      prog_len = 5'd0; start = 1'b1;
      tick();
      start = 1'b0;
      chk("t3_done", 32'(done), 32'd1);
      chk("t3_busy", 32'(busy), 32'd0);
      chk("t3_ins", instruction_out, NOP);
      tick();
      chk("t3_done_low", 32'(done), 32'd0);
      chk("t3_busy_low", 32'(busy), 32'd0);

      // Scenario 4: reset during the second issue cycle.
      prog_len = 5'd4; start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      chk("t4_first", instruction_out, prog1[0]);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("t4_ins", instruction_out, NOP);
      chk("t4_busy", 32'(busy), 32'd0);
      chk("t4_vld", 32'(issue_valid), 32'd0);
      for (int i = 0; i < 8; i++) begin
         tick();
         chk($sformatf("t4_nodone%0d", i), 32'(done), 32'd0);
      end
      run_prog(4, 0, 32'd0, 1'b0, 1'b0, "t4r", dat);

      // Scenario 5: writes during a run are dropped.
      run_prog(4, 20, 32'd0, 1'b0, 1'b1, "t5", dat);
      run_prog(4, 0, 32'd0, 1'b0, 1'b0, "t5b", dat);

      // Randomized programs, stalls, write-at-start and oversize prog_len.
      for (int it = 0; it < 8; it++) begin
         for (int a = 0; a < 16; a++) begin
            logic [31:0] w = $urandom;
            case ($urandom_range(4))
               0: w[31:26] = 6'd0;
               1: w[31:26] = 6'd1;
               2: w[31:26] = 6'd2;
               3: w[31:26] = 6'h3F;
               default: ;
            endcase
            w[25:11] = 15'($urandom_range(0, 32767) & 15'h18C6);
            load_word(a, w);
         end
         rl = (it == 0) ? 31 : ((it == 1) ? 16 : int'($urandom_range(1, 20)));
         run_prog(rl, 25, 32'd0, bit'($urandom_range(1)), bit'($urandom_range(1)),
                  $sformatf("rnd%0d", it), dat);
      end

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
